// File: rtl/sync_cntr_monitor.sv
// Sequence checker for a 3-bit up-counter: step/hold/error classification, wrap and stall reporting.
// Optional saturating error counter enabled by defining SYNC_CNTR_MON_ERRCNT_EN.
module sync_cntr_monitor #(
  parameter int STALL_LIMIT = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic [2:0]           q,
  output logic                 wrap_pulse,
  output logic [7:0]           wrap_count,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 stall,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_STALLED = 2'd2
  } state_e;

  localparam logic [4:0] STALL_LIM_C = 5'(STALL_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  prev_q, prev_d;
  logic [3:0]  run_q, run_d;
  logic        wrap_pulse_q, wrap_pulse_d;
  logic [7:0]  wrap_count_q, wrap_count_d;
  logic        err_q, err_d;
  logic        stall_q;

  logic [2:0]  prev_inc;
  logic [4:0]  run_inc;
  logic        is_step;
  logic        is_hold;
  logic        checking;

  assign prev_inc = prev_q + 3'd1;
  assign run_inc  = {1'b0, run_q} + 5'd1;
  assign is_step  = (q == prev_inc);
  assign is_hold  = (q == prev_q);
  assign checking = (state_q == ST_LOCKED) || (state_q == ST_STALLED);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    run_d        = run_q;
    wrap_pulse_d = 1'b0;
    wrap_count_d = wrap_count_q;
    err_d        = err_q;
    case (state_q)
      ST_SYNC: begin
        prev_d  = q;
        run_d   = 4'd0;
        state_d = ST_LOCKED;
      end
      ST_LOCKED, ST_STALLED: begin
        if (is_step) begin
          prev_d  = q;
          run_d   = 4'd0;
          state_d = ST_LOCKED;
          if (prev_q == 3'd7) begin
            wrap_pulse_d = 1'b1;
            wrap_count_d = wrap_count_q + 8'd1;
          end
        end else if (is_hold) begin
          if (state_q == ST_STALLED) begin
            // run keeps counting while stalled but pins at its maximum
            run_d = (run_q == 4'd15) ? 4'd15 : run_inc[3:0];
          end else begin
            run_d = run_inc[3:0];
            if (run_inc == STALL_LIM_C) begin
              state_d = ST_STALLED;
            end
          end
        end else begin
          err_d   = 1'b1;
          prev_d  = q;
          run_d   = 4'd0;
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q      <= ST_SYNC;
      prev_q       <= 3'd0;
      run_q        <= 4'd0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= 8'd0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
      err_q        <= err_d;
      stall_q      <= (state_d == ST_STALLED);
    end
  end

`ifdef SYNC_CNTR_MON_ERRCNT_EN
  logic                 err_event;
  logic [ERR_CNT_W-1:0] err_count_q;

  assign err_event = checking && !is_step && !is_hold;

  // Saturates at all-ones rather than wrapping back to zero
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      err_count_q <= '0;
    end else if (err_event && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_checking;
  assign unused_checking = checking;
  assign err_count       = '0;
`endif

  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;
  assign err        = err_q;
  assign stall      = stall_q;
  assign state      = state_q;

endmodule

// File: tb/tb_sync_cntr_monitor.sv
// Bench for sync_cntr_monitor: vector table plus directed stall/wrap/reset sequences, scoreboard-checked.
module tb_sync_cntr_monitor;

  localparam int ERR_W = 2;
  localparam int OUT_W = 15;

  logic             clk = 1'b0;
  logic             clear_n;
  logic [2:0]       q;
  logic             wrap_pulse;
  logic [7:0]       wrap_count;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic             stall;
  logic [1:0]       state;

  always #5 clk = ~clk;

  sync_cntr_monitor #(.STALL_LIMIT(4), .ERR_CNT_W(ERR_W)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .q          (q),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err        (err),
    .err_count  (err_count),
    .stall      (stall),
    .state      (state)
  );

  typedef struct {
    logic       clear_n;
    logic [2:0] q;
    logic       wp;
    logic [7:0] wc;
    logic       e;
    logic [1:0] ec;
    logic       st;
    logic [1:0] sta;
  } vec_t;

  vec_t             vecs[$];
  logic [OUT_W-1:0] exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  function automatic vec_t mk(input int cn, input int qv, input int wp, input int wc,
                              input int e, input int ec, input int st, input int sta);
    vec_t v;
    v.clear_n = 1'(cn);
    v.q       = 3'(qv);
    v.wp      = 1'(wp);
    v.wc      = 8'(wc);
    v.e       = 1'(e);
    v.ec      = 2'(ec);
    v.st      = 1'(st);
    v.sta     = 2'(sta);
    return v;
  endfunction

  task automatic add(input int cn, input int qv, input int wp, input int wc,
                     input int e, input int ec, input int st, input int sta);
    vecs.push_back(mk(cn, qv, wp, wc, e, ec, st, sta));
  endtask

  task automatic check(input string name);
    logic [OUT_W-1:0] act;
    logic [OUT_W-1:0] exp;
    act = {wrap_pulse, wrap_count, err, err_count, stall, state};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: output seen with no expected entry queued", name);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: got wp=%0d wc=%0d err=%0d ec=%0d stall=%0d state=%0d, want wp=%0d wc=%0d err=%0d ec=%0d stall=%0d state=%0d",
                 name, act[14], act[13:6], act[5], act[4:3], act[2], act[1:0],
                 exp[14], exp[13:6], exp[5], exp[4:3], exp[2], exp[1:0]);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    logic [1:0] ec_eff;
`ifdef SYNC_CNTR_MON_ERRCNT_EN
    ec_eff = v.ec;
`else
    ec_eff = 2'd0;
`endif
    @(negedge clk);
    clear_n = v.clear_n;
    q       = v.q;
    exp_q.push_back({v.wp, v.wc, v.e, ec_eff, v.st, v.sta});
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic step(input int cn, input int qv, input int wp, input int wc,
                      input int e, input int ec, input int st, input int sta, input string name);
    apply(mk(cn, qv, wp, wc, e, ec, st, sta), name);
  endtask

  initial begin
    clear_n = 1'b0;
    q       = 3'd0;

    // Reset hold with q=5, then first sample 5 and a clean step to 6
    for (int i = 0; i < 3; i++) add(0, 5, 0, 0, 0, 0, 0, 0);
    add(1, 5, 0, 0, 0, 0, 0, 1);
    add(1, 6, 0, 0, 0, 0, 0, 1);

    // Clean run 0..7,0..7,0: two single-cycle wraps
    add(0, 3, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i < 8; i++) add(1, i, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 0, 0, 1);
    for (int i = 1; i < 8; i++) add(1, i, 0, 1, 0, 0, 0, 1);
    add(1, 0, 1, 2, 0, 0, 0, 1);

    // Stall with limit 4: 1,2,3,4,4,4,4,4,5
    for (int i = 1; i < 5; i++) add(1, i, 0, 2, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 4, 0, 2, 0, 0, 0, 1);
    add(1, 4, 0, 2, 0, 0, 1, 2);
    add(1, 5, 0, 2, 0, 0, 0, 1);

    // Steps through a third wrap, then skip error 2,3,5,6,7
    add(1, 6, 0, 2, 0, 0, 0, 1);
    add(1, 7, 0, 2, 0, 0, 0, 1);
    add(1, 0, 1, 3, 0, 0, 0, 1);
    add(1, 1, 0, 3, 0, 0, 0, 1);
    add(1, 2, 0, 3, 0, 0, 0, 1);
    add(1, 3, 0, 3, 0, 0, 0, 1);
    add(1, 5, 0, 3, 1, 1, 0, 1);
    add(1, 6, 0, 3, 1, 1, 0, 1);
    add(1, 7, 0, 3, 1, 1, 0, 1);

    // Stall at 7 with wc=3 and err=1, then a one-cycle reset
    for (int i = 0; i < 3; i++) add(1, 7, 0, 3, 1, 1, 0, 1);
    add(1, 7, 0, 3, 1, 1, 1, 2);
    add(0, 7, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 1);
    add(1, 3, 0, 0, 0, 0, 0, 1);
    add(1, 4, 0, 0, 0, 0, 0, 1);

    // Five skip errors: counter reads 1,2,3,3,3
    add(1, 0, 0, 0, 1, 1, 0, 1);
    add(1, 2, 0, 0, 1, 2, 0, 1);
    add(1, 4, 0, 0, 1, 3, 0, 1);
    add(1, 6, 0, 0, 1, 3, 0, 1);
    add(1, 0, 0, 0, 1, 3, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec[%0d]", i));
    end

    // Long stall (run saturates), error exits stall, then wrap exits stall
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 3, 0, 1, "hold_pre_stall");
    step(1, 0, 0, 0, 1, 3, 1, 2, "stall_enter");
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 1, 3, 1, 2, "stall_long");
    step(1, 3, 0, 0, 1, 3, 0, 1, "stall_exit_err");
    for (int i = 4; i < 8; i++) step(1, i, 0, 0, 1, 3, 0, 1, "steps_to_7");
    for (int i = 0; i < 3; i++) step(1, 7, 0, 0, 1, 3, 0, 1, "hold7_pre_stall");
    step(1, 7, 0, 0, 1, 3, 1, 2, "stall7_enter");
    step(1, 0, 1, 1, 1, 3, 0, 1, "stall_exit_wrap");
    step(1, 1, 0, 1, 1, 3, 0, 1, "wrap_pulse_drop");

    // Reset on the edge that would have wrapped
    for (int i = 2; i < 8; i++) step(1, i, 0, 1, 1, 3, 0, 1, "pre_wrap_steps");
    step(0, 0, 0, 0, 0, 0, 0, 0, "reset_mid_wrap");
    step(1, 0, 0, 0, 0, 0, 0, 1, "resync_after_reset");
    step(1, 1, 0, 0, 0, 0, 0, 1, "resume_after_reset");

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_cntr_monitor.md
# sync_cntr_monitor

Downstream checker for the 3-bit synchronous up-counter. Samples the counter's `q` bus every clock and checks that each new value is the previous value plus one, modulo 8. Reports wrap-around events and counts them, flags sequence errors, and detects a stalled counter. Shares `clk` and `clear_n` with the counter, so both leave reset on the same edge.

## Interface

Parameters:
- `STALL_LIMIT`, default 4: number of consecutive repeated samples that declares a stall. Legal range 1..15.
- `ERR_CNT_W`, default 8: width of the error counter. Minimum 1.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `clear_n`, input, 1: synchronous, active-low reset.
- `q`, input, 3: count value from the upstream counter.
- `wrap_pulse`, output, 1: one-cycle pulse on each valid 7→0 step.
- `wrap_count`, output, 8: number of wraps, modulo 256.
- `err`, output, 1: sticky sequence-error flag.
- `err_count`, output, `ERR_CNT_W`: saturating count of sequence errors.
- `stall`, output, 1: high while in state STALLED.
- `state`, output, 2: debug view of the state machine. SYNC=0, LOCKED=1, STALLED=2.

## Operation

Internal registers:
- `prev[2:0]`: last accepted sample.
- `run[3:0]`: count of consecutive repeated samples.

States:
- **SYNC**
  - Entered on reset.
  - Captures `prev <= q` and `run <= 0`, with no checking.
  - Always moves to LOCKED on the next edge.
- **LOCKED**, on each edge compares `q` with `prev`:
  - **Step** (`q == prev+1` mod 8): set `prev <= q` and `run <= 0`. If `prev == 7`, assert `wrap_pulse` and increment `wrap_count` (it wraps 255→0).
  - **Hold** (`q == prev`): `run <= run+1`. When `run+1 == STALL_LIMIT`, go to STALLED.
  - **Error** (any other value):
    - Set `err <= 1`.
    - Increment `err_count`; it saturates at all-ones.
    - Resynchronise with `prev <= q` and `run <= 0`.
    - Stay in LOCKED.
- **STALLED**:
  - Hold: stay in STALLED. `run` saturates at 15.
  - Step: handled as in LOCKED, including the wrap check, then go to LOCKED.
  - Error: handled as in LOCKED, then go to LOCKED.

Rules:
- `err` clears only on reset.
- Only one event occurs per cycle. Step, hold and error are mutually exclusive by construction.
- A wrap seen on the step that leaves STALLED counts normally.
- The first sample after reset is never checked.

## Timing

- All outputs are registered. Sample `q` at edge N; the response is visible after edge N.
- Reset: when `clear_n == 0` at an edge, the following values apply after that edge:

  | Signal | Value |
  |---|---|
  | `state` | SYNC |
  | `wrap_pulse` | 0 |
  | `wrap_count` | 0 |
  | `err` | 0 |
  | `err_count` | 0 |
  | `stall` | 0 |
  | `prev` | 0 |
  | `run` | 0 |

- Reset has priority over every event, including mid-stall or mid-wrap. `q` is ignored while reset is asserted.
- Edge after the release of `clear_n`: SYNC captures `q`. The first check happens on the following edge.
- `wrap_pulse` is high for exactly one cycle per wrap, with no stretching. Back-to-back wraps are impossible with 8 steps.
- `stall` rises after the edge on which the `STALL_LIMIT`-th consecutive hold is sampled. It falls after the edge that samples a step or an error.
- Timing example with `STALL_LIMIT=1`: a single repeat sets `stall` one cycle later.

## Configuration

- `SYNC_CNTR_MON_ERRCNT_EN` defined:
  - `err_count` is implemented as the saturating `ERR_CNT_W`-bit counter.
- `SYNC_CNTR_MON_ERRCNT_EN` undefined:
  - No counter register.
  - `err_count` is tied to 0.
  - `err` keeps its sticky behaviour; everything else is unchanged.

## Test plan

1. **Reset hold:** `clear_n=0` for 3 cycles with `q=5`. Required response:
   - All outputs are 0 and `state=0`.
   - After release, a first sample of `q=5` followed by `q=6` gives no error.
2. **Clean run:** after reset, `q` steps 0,1,…,7,0,…,7,0. Required response:
   - `wrap_pulse` is high exactly twice, one cycle each, on the edges after sampling the 0s that follow 7.
   - `wrap_count=2`, `err=0`, `stall=0`.
3. **Skip error:** sequence 2,3,5,6,7. Required response:
   - `err=1` and `err_count=1` after the edge sampling 5.
   - 6 and 7 cause no further increment.
   - `err` stays 1.
4. **Stall (`STALL_LIMIT=4`):** sequence 3,4,4,4,4,4,5. Required response:
   - `stall=1` after the edge sampling the fifth 4.
   - `stall=0` after the edge sampling 5.
   - `err=0`.
5. **Saturation (`ERR_CNT_W=2`, macro defined):** inject 5 skip errors. Required response:
   - `err_count` reads 1,2,3,3,3.
   - With the macro undefined, `err_count=0` throughout and `err=1`.
6. **Reset mid-operation:** with `wrap_count=3`, `err=1` and STALLED, drive `clear_n=0` for 1 cycle. Required response:
   - Every output is 0 and `state=SYNC` after that edge.
   - Counting resumes cleanly.
